// File: rtl/fifo36_pkt_gate.sv
// rtl/fifo36_pkt_gate.sv - store-and-forward fifo36 packet gate with error/oversize drop
module fifo36_pkt_gate #(
  parameter int AWIDTH = 9,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic [35:0]       data_i,
  input  logic              src_rdy_i,
  output logic              dst_rdy_o,
  output logic [35:0]       data_o,
  output logic              src_rdy_o,
  input  logic              dst_rdy_i,
  output logic [AWIDTH:0]   occupied,
  output logic [CNT_W-1:0]  drop_count
);

  localparam int DEPTH = 1 << AWIDTH;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_DROP  = 2'd2;

  localparam logic [AWIDTH-1:0] PTR_ONE = {{(AWIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [35:0]       mem_q [DEPTH];
  logic [35:0]       ram_dout_q;

  logic [1:0]        state_q, state_d;
  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH-1:0] commit_ptr_q, commit_ptr_d;
  logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [AWIDTH-1:0] fetch_ptr_q, fetch_ptr_d;
  logic [AWIDTH-1:0] wr_ptr_inc, ptr_diff;
  logic              ram_vld_q, ram_vld_d;
  logic              out_vld_q, out_vld_d;
  logic [35:0]       out_q, out_d;
  logic [CNT_W-1:0]  drop_q, drop_d;

  logic              full;
  logic              in_sof, in_eof, in_err;
  logic              in_xfer, out_xfer, load_out, fetch;
  logic              mem_we, drop_inc;

  assign in_sof     = data_i[32];
  assign in_eof     = data_i[33];
  assign in_err     = in_sof & in_eof;
  assign wr_ptr_inc = wr_ptr_q + PTR_ONE;
  assign full       = (wr_ptr_inc == rd_ptr_q);

  // Ready depends only on state and the full flag, never on src_rdy_i
  assign dst_rdy_o  = (state_q == ST_DROP) | ~full;
  assign in_xfer    = src_rdy_i & dst_rdy_o;
  assign out_xfer   = out_vld_q & dst_rdy_i;

  // Two-stage read pipeline: RAM output register, then the prefetch register driving data_o.
  // rd_ptr only moves on a downstream transfer, so lines in flight still count as occupied.
  assign load_out   = ram_vld_q & (~out_vld_q | dst_rdy_i);
  assign fetch      = ~clear & (fetch_ptr_q != commit_ptr_q) & (~ram_vld_q | load_out);

  assign ptr_diff   = wr_ptr_q - rd_ptr_q;
  assign occupied   = {1'b0, ptr_diff};
  assign data_o     = out_q;
  assign src_rdy_o  = out_vld_q;
  assign drop_count = drop_q;

  // Ingress FSM: write packet lines, commit on EOF, rewind on error or oversize
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    mem_we       = 1'b0;
    drop_inc     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_xfer && in_sof && !in_eof) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_inc;
          state_d  = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (full && (commit_ptr_q == rd_ptr_q)) begin
          // Packet alone fills the buffer: it can never be committed
          wr_ptr_d = commit_ptr_q;
          drop_inc = 1'b1;
          state_d  = ST_DROP;
        end else if (in_xfer) begin
          if (in_err) begin
            wr_ptr_d = commit_ptr_q;
            drop_inc = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_inc;
            if (in_eof) begin
              commit_ptr_d = wr_ptr_inc;
              state_d      = ST_IDLE;
            end
          end
        end
      end
      ST_DROP: begin
        if (in_xfer && in_eof) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (clear) begin
      state_d      = ST_IDLE;
      wr_ptr_d     = '0;
      commit_ptr_d = '0;
      mem_we       = 1'b0;
      drop_inc     = 1'b0;
    end
  end

  // Saturating drop counter next value; clear leaves it untouched
  always_comb begin
    drop_d = drop_q;
    if (drop_inc && (drop_q != {CNT_W{1'b1}})) begin
      drop_d = drop_q + CNT_ONE;
    end
  end

  // Egress side: advance fetch/read pointers and move lines through the read pipeline
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    fetch_ptr_d = fetch_ptr_q;
    ram_vld_d   = ram_vld_q;
    out_vld_d   = out_vld_q;
    out_d       = out_q;
    if (out_xfer) begin
      rd_ptr_d  = rd_ptr_q + PTR_ONE;
      out_vld_d = 1'b0;
    end
    if (load_out) begin
      out_d     = ram_dout_q;
      out_vld_d = 1'b1;
      ram_vld_d = 1'b0;
    end
    if (fetch) begin
      fetch_ptr_d = fetch_ptr_q + PTR_ONE;
      ram_vld_d   = 1'b1;
    end
    if (clear) begin
      rd_ptr_d    = '0;
      fetch_ptr_d = '0;
      ram_vld_d   = 1'b0;
      out_vld_d   = 1'b0;
    end
  end

  // Buffer RAM: write port from the ingress FSM, registered read port for the prefetch pipeline
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= data_i;
    end
    if (fetch) begin
      ram_dout_q <= mem_q[fetch_ptr_q];
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      fetch_ptr_q  <= '0;
      ram_vld_q    <= 1'b0;
      out_vld_q    <= 1'b0;
      out_q        <= '0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fetch_ptr_q  <= fetch_ptr_d;
      ram_vld_q    <= ram_vld_d;
      out_vld_q    <= out_vld_d;
      out_q        <= out_d;
      drop_q       <= drop_d;
    end
  end

endmodule
